// File: rtl/axi_rd_responder.sv
// axi_rd_responder
// AXI4 read-only responder for a synchronous instruction SRAM with
// one-cycle read latency. It accepts one burst at a time and generates
// per-beat word addresses for FIXED, INCR and WRAP bursts. R beats return
// through a 2-entry buffer that honours s_rready backpressure.
//
// Read data reaches the buffer in the cycle after sram_en. The buffer
// presents arriving data at its head in that same cycle when it is empty,
// so beat 0 is valid two cycles after the AR handshake. Data that is not
// taken in that cycle is stored, and it stays stable until it is popped.
module axi_rd_responder #(
  parameter int ADDR_W = 16,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ID_W-1:0]   s_arid,
  input  logic [31:0]       s_araddr,
  input  logic [7:0]        s_arlen,
  input  logic [2:0]        s_arsize,
  input  logic [1:0]        s_arburst,
  input  logic              s_aruser,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [ID_W-1:0]   s_rid,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              sram_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [31:0]       sram_dout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // One buffered R beat.
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  // FSM and AR side
  state_t          state;
  state_t          state_next;
  logic            arready_q;
  logic            accept;

  // Latched burst context
  logic [ID_W-1:0] id_q;
  logic [31:0]     beat_addr;
  logic [7:0]      len_q;
  burst_t          burst_q;
  logic            err_q;
  logic [7:0]      issue_cnt;

  // AR decode
  logic            wrap_len_ok;
  logic            ar_err;
  burst_t          ar_burst_eff;

  // Address generation
  logic [31:0]     wrap_mask;
  logic [31:0]     addr_plus4;
  logic [31:0]     addr_next;

  // Issue and in-flight read tracking
  logic            issue;
  logic            last_issue;
  logic            inflight;
  logic            inflight_last;
  logic [1:0]      inflight_resp;

  // Output buffer
  beat_t           fifo_mem [2];
  logic            rd_ptr;
  logic            wr_ptr;
  logic [1:0]      count;
  beat_t           arrive;
  beat_t           head;
  logic            r_valid;
  logic            pop;
  logic            deq;
  logic            push;

  // The uncached hint has no effect on a read-only SRAM port.
  logic            unused_aruser;
  assign unused_aruser = s_aruser;

  // Classify the incoming request: find the burst type to execute and
  // whether every beat of it returns SLVERR.
  // NOTE: every signal written in an always_comb gets a default value first.
  // Without that, a path that skips an assignment infers a latch.
  always_comb begin
    wrap_len_ok  = (s_arlen == 8'd1) || (s_arlen == 8'd3) ||
                   (s_arlen == 8'd7) || (s_arlen == 8'd15);
    ar_burst_eff = burst_t'(s_arburst);
    ar_err       = 1'b0;
    if (s_arburst == BURST_RSVD) begin
      ar_burst_eff = BURST_INCR;
      ar_err       = 1'b1;
    end else if ((s_arburst == BURST_WRAP) && !wrap_len_ok) begin
      ar_burst_eff = BURST_INCR;
      ar_err       = 1'b1;
    end
    if (s_arsize != 3'b010) begin
      ar_err = 1'b1;
    end
  end

  // Compute the next beat address. The WRAP mask equals (len+1)*4-1.
  always_comb begin
    wrap_mask  = {22'd0, len_q, 2'b11};
    addr_plus4 = beat_addr + 32'd4;
    addr_next  = addr_plus4;
    case (burst_q)
      BURST_FIXED: addr_next = beat_addr;
      BURST_WRAP:  addr_next = (beat_addr & ~wrap_mask) | (addr_plus4 & wrap_mask);
      default:     addr_next = addr_plus4;
    endcase
  end

  // AR acceptance and SRAM issue. A read is issued only when the buffered
  // beats plus the read still in flight leave space for its data.
  always_comb begin
    accept     = arready_q && s_arvalid;
    issue      = (state == ST_BURST) &&
                 (({1'b0, count} + {2'b00, inflight}) < 3'd2);
    last_issue = issue && (issue_cnt == len_q);
  end

  // Buffer head selection. When the buffer is empty, the arriving SRAM
  // data is the head.
  always_comb begin
    arrive  = {sram_dout, inflight_resp, inflight_last};
    r_valid = (count != 2'd0) || inflight;
    head    = (count != 2'd0) ? fifo_mem[rd_ptr] : arrive;
    pop     = r_valid && s_rready;
    deq     = pop && (count != 2'd0);
    push    = inflight && !(pop && (count == 2'd0));
  end

  // Next-state logic: one burst at a time, and no AR/R overlap.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept)              state_next = ST_BURST;
      ST_BURST: if (last_issue)          state_next = ST_DRAIN;
      ST_DRAIN: if (pop && head.last)    state_next = ST_IDLE;
      default:                           state_next = ST_IDLE;
    endcase
  end

  // State register. s_arready is registered from the next state.
  // NOTE: sequential state uses non-blocking assignments. Then every flop
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      arready_q <= 1'b1;
    end else begin
      state     <= state_next;
      arready_q <= (state_next == ST_IDLE);
    end
  end

  // Burst context. It is loaded at AR acceptance and advanced on each issue.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id_q      <= '0;
      beat_addr <= '0;
      len_q     <= '0;
      burst_q   <= BURST_INCR;
      err_q     <= 1'b0;
      issue_cnt <= '0;
    end else if (accept) begin
      id_q      <= s_arid;
      beat_addr <= s_araddr & 32'hFFFF_FFFC;
      len_q     <= s_arlen;
      burst_q   <= ar_burst_eff;
      err_q     <= ar_err;
      issue_cnt <= '0;
    end else if (issue) begin
      beat_addr <= addr_next;
      issue_cnt <= issue_cnt + 8'd1;
    end
  end

  // Track the read issued last cycle, with its response and last tags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      inflight_resp <= RESP_OKAY;
    end else begin
      inflight      <= issue;
      inflight_last <= last_issue;
      inflight_resp <= err_q ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Buffer storage. The valid state lives in the pointers and count.
  // NOTE: the storage array has no reset. Nothing reads an entry before it
  // is written, and leaving the reset off keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= arrive;
    end
  end

  // Buffer pointers and occupancy. A push and a pop in the same cycle
  // leave the count unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (deq)  rd_ptr <= ~rd_ptr;
      case ({push, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Outputs. R payload is forced to zero while no beat is valid.
  assign s_arready = arready_q;
  assign s_rid     = id_q;
  assign s_rvalid  = r_valid;
  assign s_rdata   = r_valid ? head.data : 32'd0;
  assign s_rresp   = r_valid ? head.resp : RESP_OKAY;
  assign s_rlast   = r_valid && head.last;
  assign sram_en   = issue;
  assign sram_addr = beat_addr[ADDR_W+1:2];

endmodule

// File: doc/axi_rd_responder.md
# axi_rd_responder

Single-port AXI4 read-only responder sitting in front of a synchronous instruction SRAM. It serves the burst read requests issued by the fetch refill/uncached path: single-beat INCR, 16-beat WRAP, and FIXED/INCR bursts up to 256 beats. It generates per-beat word addresses, reads the SRAM with one-cycle latency, and returns data on the R channel through a 2-entry buffer that fully honours `s_rready` backpressure.

## Interface
Parameters:
- `ADDR_W`, 16: SRAM word-address width. The SRAM index is `beat_addr[ADDR_W+1:2]`; higher address bits are ignored.
- `ID_W`, 4: AXI ID width.

Ports:
- `clk`  in  1  single clock; everything is on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `s_arid`  in  ID_W  request ID.
- `s_araddr`  in  32  byte start address. Bits [1:0] are ignored.
- `s_arlen`  in  8  beats minus 1.
- `s_arsize`  in  3  beat size. Only 3'b010 (4 bytes) is supported.
- `s_arburst`  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- `s_aruser`  in  1  uncached hint. Accepted and ignored.
- `s_arvalid` in 1, `s_arready` out 1: AR handshake.
- `s_rid`  out  ID_W  latched `s_arid`.
- `s_rdata`  out  32  beat data.
- `s_rresp`  out  2  00 OKAY, 10 SLVERR.
- `s_rlast`  out  1  marks the final beat.
- `s_rvalid` out 1, `s_rready` in 1: R handshake.
- `sram_en`  out  1  SRAM read strobe.
- `sram_addr`  out  ADDR_W  SRAM word index.
- `sram_dout`  in  32  SRAM data, valid the cycle after `sram_en`.

## Operation
State machine:
- **IDLE**
  - `s_arready`=1.
  - On `s_arvalid`, latch id, addr, len, burst and error flag; clear the beat counter; go to BURST.
- **BURST**
  - Issue one SRAM read per cycle while `occupancy + inflight < 2`. `occupancy` is the number of buffer entries; `inflight` is 1 if `sram_en` was asserted in the previous cycle.
  - Each issue advances `beat_addr` and increments the issue counter.
  - When the issue with index == len is made, go to DRAIN.
- **DRAIN**
  - No new issues.
  - When the R handshake with `s_rlast`=1 completes, go to IDLE.

Address generation (byte address, 32-bit arithmetic, wraps at 2^32, no 4 KB check):
- FIXED: the address is held for every beat.
- INCR: address + 4 per beat.
- WRAP: `mask = (len+1)*4 - 1`; next address = `(addr & ~mask) | ((addr + 4) & mask)`. Legal only for len ∈ {1, 3, 7, 15}.

Error handling:
- SLVERR is returned on every beat of the burst when `s_arsize != 2`, when burst = 11, or when WRAP has an illegal len.
- Burst 11 and illegal-len WRAP are otherwise executed as INCR.
- Data is still read from the SRAM on error bursts; exactly len+1 beats are always returned.

Output buffer:
- 2-entry FIFO. SRAM data is written into it the cycle after `sram_en`, tagged with the resp value and a last flag (issue index == len).
- The head drives `s_rdata`/`s_rresp`/`s_rlast`; `s_rvalid` = buffer non-empty.
- Pop on `s_rvalid & s_rready`. A simultaneous push and pop is legal and leaves occupancy unchanged.
- The issue credit rule guarantees the buffer never overflows.

## Timing
- Reset values (asynchronous): state IDLE, `s_arready`=1, `s_rvalid`=0, `s_rlast`=0, `s_rresp`=0, `s_rid`=0, `s_rdata`=0, `sram_en`=0, `sram_addr`=0; buffer empty, counters 0.
- `s_arready` is a registered output derived from state; it is 0 in BURST and DRAIN.
- AR handshake at cycle T: `sram_en` for beat 0 at T+1; `s_rvalid` for beat 0 at T+2.
- With `s_rready` held at 1, one beat is delivered per cycle, and the last beat (beat len) is delivered at T+2+len.
- `s_arready` returns to 1 in the cycle after the last-beat R handshake, so the next AR can be accepted at T+3+len at the earliest. There is no AR/R overlap.
- With `s_rready`=0, `s_rvalid` and all R payload signals stay stable until the handshake completes, as AXI requires.
- `sram_en` stalls once two beats are buffered or in flight, and resumes in the cycle after a pop.
- Reset asserted mid-burst: the burst is dropped immediately, the buffer is cleared, and no further beats are returned after reset is released.

## Test plan
1. **Single beat.** AR addr 0x0000_0040, len 0, INCR, size 2, id 5, with SRAM[0x10]=0xDEADBEEF → one beat 0xDEADBEEF, rid 5, resp 00, rlast=1 at T+2; `s_arready`=1 at T+3.
2. **INCR16.** AR addr 0x100, len 15, `s_rready`=1 → data from SRAM words 0x40..0x4F on consecutive cycles T+2..T+17; rlast only on the 16th beat.
3. **WRAP16.** AR addr 0x1C8, len 15 → word sequence 0x72..0x7F, then 0x70, 0x71; rlast on the word-0x71 beat.
4. **Backpressure.** INCR8 with `s_rready` toggled 1,0,0,1,0,1... → all 8 beats delivered in order with no loss or duplication; payload stable while stalled; never more than 2 beats buffered or in flight.
5. **Errors.** AR with size 3, len 3 → 4 beats, all resp 10, rlast on the 4th. WRAP with len 2 → 3 beats at INCR addresses, all resp 10.
6. **Reset mid-burst.** Assert `resetn`=0 at beat 5 of an INCR16 → outputs take reset values immediately. After release: `s_arready`=1, `s_rvalid`=0, and a new single-beat AR completes correctly.
